// File: rtl/tx_intf_pkg.sv
// Shared tx_intf definitions: request field positions, default register
// addresses and the packed tx request entry.
package tx_intf_pkg;
  localparam int LEN_LSB  = 0;
  localparam int QIDX_LSB = 16;
  localparam int PRIO_LSB = 18;
  localparam int SN_W     = 10;

  localparam logic [4:0] REQ_ADDR_DEF = 5'h17;
  localparam logic [4:0] CLR_ADDR_DEF = 5'h18;

  typedef struct packed {
    logic [1:0]      prio;
    logic [1:0]      qidx;
    logic [15:0]     len;
    logic [SN_W-1:0] sn;
  } tx_req_t;

  localparam int TX_REQ_W = $bits(tx_req_t);
endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with a registered head stage.
// level counts every stored entry, including the one held in the head register.
module sync_fifo_fwft #(
  parameter int W     = 30,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   mem_cnt, level_q;
  logic          out_vld;
  logic [W-1:0]  out_q;
  logic          wr_ok, rd_ok, load, from_mem, bypass, mem_wr;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = !out_vld;
  assign level = level_q;
  assign dout  = out_q;

  // Head register refills from memory first; an empty FIFO takes the push
  // straight into the head so it is visible on the next cycle.
  always_comb begin
    wr_ok    = push && !full;
    rd_ok    = pop && out_vld;
    load     = !out_vld || rd_ok;
    from_mem = load && (mem_cnt != '0);
    bypass   = load && (mem_cnt == '0) && wr_ok;
    mem_wr   = wr_ok && !bypass;
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      level_q <= '0;
      out_vld <= 1'b0;
      out_q   <= '0;
    end else begin
      if (mem_wr)   wr_ptr <= wr_ptr + AW'(1);
      if (from_mem) rd_ptr <= rd_ptr + AW'(1);
      mem_cnt <= mem_cnt + (AW+1)'(mem_wr) - (AW+1)'(from_mem);
      level_q <= level_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      if (from_mem) begin
        out_q   <= mem[rd_ptr];
        out_vld <= 1'b1;
      end else if (bypass) begin
        out_q   <= din;
        out_vld <= 1'b1;
      end else if (load) begin
        out_vld <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/tx_req_fifo.sv
// Buffers CPU-written tx requests, stamps each with a 10-bit sequence number
// and hands them to the tx engine. Optional drop counter: TX_REQ_DROP_CNT_EN.
module tx_req_fifo
  import tx_intf_pkg::*;
#(
  parameter int         DEPTH    = 64,
  parameter int         AW       = 6,
  parameter logic [4:0] REQ_ADDR = REQ_ADDR_DEF,
  parameter logic [4:0] CLR_ADDR = CLR_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        slv_reg_wren,
  input  logic [4:0]  axi_awaddr_core,
  input  logic [31:0] slv_reg_wdata,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [15:0] req_len,
  output logic [1:0]  req_queue_idx,
  output logic [1:0]  req_linux_prio,
  output logic [9:0]  req_pkt_sn,
  output logic [AW:0] fifo_level,
  output logic        overflow
`ifdef TX_REQ_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);
  logic            push, clr, full, empty, accept, drop;
  logic [SN_W-1:0] sn_cnt;
  tx_req_t         din, dout;
  logic            unused_wdata;

  assign push   = slv_reg_wren && (axi_awaddr_core == REQ_ADDR);
  assign clr    = slv_reg_wren && (axi_awaddr_core == CLR_ADDR);
  assign accept = push && !full;
  assign drop   = push && full;

  assign unused_wdata = ^slv_reg_wdata[31:20];

  always_comb begin
    din      = '0;
    din.prio = slv_reg_wdata[PRIO_LSB +: 2];
    din.qidx = slv_reg_wdata[QIDX_LSB +: 2];
    din.len  = slv_reg_wdata[LEN_LSB +: 16];
    din.sn   = sn_cnt;
  end

  sync_fifo_fwft #(.W(TX_REQ_W), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (req_ready),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign req_valid      = !empty;
  assign req_len        = dout.len;
  assign req_queue_idx  = dout.qidx;
  assign req_linux_prio = dout.prio;
  assign req_pkt_sn     = dout.sn;

  // A drop in the same cycle as a clear must leave the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sn_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) sn_cnt <= sn_cnt + SN_W'(1);
      if (drop)     overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
    end
  end

`ifdef TX_REQ_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                    drop_cnt <= '0;
    else if (clr)               drop_cnt <= {15'd0, drop};
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_tx_req_fifo.sv
// Directed bench for tx_req_fifo with a reference queue of expected requests.
module tb_tx_req_fifo;
  import tx_intf_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        slv_reg_wren;
  logic [4:0]  axi_awaddr_core;
  logic [31:0] slv_reg_wdata;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_len;
  logic [1:0]  req_queue_idx;
  logic [1:0]  req_linux_prio;
  logic [9:0]  req_pkt_sn;
  logic [AW:0] fifo_level;
  logic        overflow;
`ifdef TX_REQ_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  tx_req_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .slv_reg_wren    (slv_reg_wren),
    .axi_awaddr_core (axi_awaddr_core),
    .slv_reg_wdata   (slv_reg_wdata),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_len         (req_len),
    .req_queue_idx   (req_queue_idx),
    .req_linux_prio  (req_linux_prio),
    .req_pkt_sn      (req_pkt_sn),
    .fifo_level      (fifo_level),
    .overflow        (overflow)
`ifdef TX_REQ_DROP_CNT_EN
    ,
    .drop_cnt        (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  tx_req_t    sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [9:0] m_sn;
  logic       m_ovf;
  int         m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] head();
    tx_req_t h;
    h.prio = req_linux_prio;
    h.qidx = req_queue_idx;
    h.len  = req_len;
    h.sn   = req_pkt_sn;
    return 32'(h);
  endfunction

  task automatic check_state();
    chk("level", 32'(fifo_level), 32'(sb.size()));
    chk("valid", 32'(req_valid), 32'(sb.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef TX_REQ_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    if (sb.size() != 0) chk("head", head(), 32'(sb[0]));
  endtask

  // One clock: drive inputs, update the model, check after the edge.
  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d, input logic r);
    tx_req_t e;
    logic    was_full;
    slv_reg_wren    = w;
    axi_awaddr_core = a;
    slv_reg_wdata   = d;
    req_ready       = r;
    was_full = (sb.size() == DEPTH);
    if (r && sb.size() != 0) begin
      e = sb.pop_front();
      chk("pop", head(), 32'(e));
    end
    if (w && a == 5'h17) begin
      if (!was_full) begin
        e.prio = d[19:18];
        e.qidx = d[17:16];
        e.len  = d[15:0];
        e.sn   = m_sn;
        sb.push_back(e);
        m_sn = m_sn + 10'd1;
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end else if (w && a == 5'h18) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    @(posedge clk);
    @(negedge clk);
    slv_reg_wren = 1'b0;
    check_state();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    slv_reg_wren = 1'b0;
    req_ready    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_sn   = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
    check_state();
    chk("rst_len", 32'(req_len), 32'd0);
    chk("rst_qidx_prio_sn", {20'd0, req_queue_idx, req_linux_prio, req_pkt_sn}, 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    slv_reg_wren    = 1'b0;
    axi_awaddr_core = '0;
    slv_reg_wdata   = '0;
    req_ready       = 1'b0;
    m_sn   = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
    @(negedge clk);
    do_reset();

    // Single request, held with ready low
    cyc(1'b1, 5'h17, 32'h000A_05DC, 1'b0);
    chk("t1_valid", 32'(req_valid), 32'd1);
    chk("t1_len", 32'(req_len), 32'd1500);
    chk("t1_qidx", 32'(req_queue_idx), 32'd2);
    chk("t1_prio", 32'(req_linux_prio), 32'd2);
    chk("t1_sn", 32'(req_pkt_sn), 32'd0);
    chk("t1_level", 32'(fifo_level), 32'd1);
    cyc(1'b0, 5'h00, 32'h0, 1'b0);
    cyc(1'b0, 5'h00, 32'h0, 1'b1);

    // Three requests then back-to-back pops
    cyc(1'b1, 5'h17, 32'hFFF1_0040, 1'b0);
    cyc(1'b1, 5'h17, 32'h0006_0080, 1'b0);
    cyc(1'b1, 5'h17, 32'h000F_FFFF, 1'b0);
    repeat (3) cyc(1'b0, 5'h00, 32'h0, 1'b1);
    chk("t2_empty_valid", 32'(req_valid), 32'd0);
    chk("t2_empty_level", 32'(fifo_level), 32'd0);

    // Fill, overflow, sn not consumed by the drop
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 5'h17, $urandom, 1'b0);
    cyc(1'b1, 5'h17, 32'h0000_1234, 1'b0);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_level", 32'(fifo_level), 32'd64);
`ifdef TX_REQ_DROP_CNT_EN
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    cyc(1'b0, 5'h00, 32'h0, 1'b1);
    cyc(1'b1, 5'h17, 32'h0001_0200, 1'b0);
    // Full with simultaneous push and pop
    cyc(1'b1, 5'h17, 32'h0002_0300, 1'b1);
    chk("t4_level", 32'(fifo_level), 32'd63);
    chk("t4_overflow", 32'(overflow), 32'd1);
    cyc(1'b1, 5'h18, 32'hDEAD_BEEF, 1'b0);
    chk("t4_clear", 32'(overflow), 32'd0);
    cyc(1'b1, 5'h05, 32'h0000_0777, 1'b0);
    chk("other_addr_level", 32'(fifo_level), 32'd63);
    repeat (DEPTH + 2) cyc(1'b0, 5'h00, 32'h0, 1'b1);

    // SN wrap with streaming push/pop
    do_reset();
    for (int i = 0; i < 1030; i++) cyc(1'b1, 5'h17, $urandom, 1'b1);
    repeat (2) cyc(1'b0, 5'h00, 32'h0, 1'b1);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) cyc(1'b1, 5'h17, $urandom, 1'b0);
    chk("t6_level5", 32'(fifo_level), 32'd5);
    do_reset();
    cyc(1'b1, 5'h17, 32'h0000_0100, 1'b0);
    chk("t6_sn0", 32'(req_pkt_sn), 32'd0);
    cyc(1'b0, 5'h00, 32'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_req_fifo.md
Name: tx_req_fifo

Overview:
- Host-to-hardware counterpart of the tx status path. The CPU issues AXI-lite register writes that describe per-packet tx requests. This block buffers them and assigns each one a 10-bit tx_pkt_sn.
- It presents requests to the tx engine through a valid/ready handshake.
- Sits inside tx_intf between the AXI-lite slave register decode and the tx scheduling logic.
- Occupancy and a sticky overflow flag are exported for register readback.

Parameters:
- DEPTH, 64, number of request entries; power of 2, 4..256.
- AW, 6, pointer width; must equal log2(DEPTH).
- REQ_ADDR, 5'h17, axi_awaddr_core value whose write pushes a request.
- CLR_ADDR, 5'h18, axi_awaddr_core value whose write (any data) clears overflow state.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- slv_reg_wren  in  1  AXI-lite register write strobe, 1 cycle.
- axi_awaddr_core  in  5  register word address of the write.
- slv_reg_wdata  in  32  write data.
- req_valid  out  1  head request available.
- req_ready  in  1  tx engine accepts head request.
- req_len  out  16  packet length in bytes (wdata[15:0]).
- req_queue_idx  out  2  wdata[17:16].
- req_linux_prio  out  2  wdata[19:18].
- req_pkt_sn  out  10  sequence number assigned at push.
- fifo_level  out  AW+1  entries currently stored, including the head.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
- Push:
  - push = slv_reg_wren && axi_awaddr_core==REQ_ADDR.
  - Accepted only if fifo_level<DEPTH, using the value registered before this cycle. A pop in the same cycle does not free space for that push.
  - Stored entry = {prio, queue_idx, len, sn_cnt}. wdata[31:20] is ignored.
- SN counter:
  - 10-bit sn_cnt increments only on an accepted push.
  - Wraps 1023->0.
  - Reset value 0, so the first request gets sn 0.
- Dropped push: sets overflow=1; sn_cnt is not incremented.
- Clear: a write to CLR_ADDR clears overflow next cycle. A drop in the same cycle as a clear wins, so overflow stays 1.
- Pop: pop = req_valid && req_ready. The head advances and fifo_level decrements.
- Output timing:
  - First-word fall-through with a registered output stage.
  - A push accepted in cycle N into an empty FIFO gives req_valid=1 with that entry in cycle N+1.
  - Back-to-back pops sustain 1 request/cycle.
  - req_* fields are stable while req_valid=1 and req_ready=0.
- Push and pop in the same cycle with 0<level<DEPTH: level is unchanged, both take effect.
- Pointers wrap modulo DEPTH. fifo_level is exact: 0..DEPTH.
- Reset values: req_valid=0, req_len=0, req_queue_idx=0, req_linux_prio=0, req_pkt_sn=0, fifo_level=0, overflow=0, pointers=0, sn_cnt=0. Memory contents are not reset.
- Reset asserted mid-operation: all queued requests are discarded and req_valid falls the cycle after rst is sampled high. The engine must not rely on in-flight entries.
- Writes to other addresses are ignored.

Optional Feature:
- Macro TX_REQ_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt[15:0].
  - Increments on each dropped push and saturates at 16'hFFFF.
  - Cleared together with overflow by a write to CLR_ADDR. A drop in the same cycle as a clear leaves drop_cnt=1.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package tx_intf_pkg holds:
  - localparams for the field bit positions (LEN_LSB=0, QIDX_LSB=16, PRIO_LSB=18);
  - SN_W=10;
  - default REQ_ADDR/CLR_ADDR;
  - the tx_req entry packed struct {prio, qidx, len, sn}, 30 bits.
- One natural sub-module, sync_fifo_fwft:
  - parameterised width/depth;
  - push/pop/full/empty/level;
  - registered FWFT output.
- tx_req_fifo keeps the address decode, SN counter, overflow/drop logic and field packing.

Test Plan:
- Reset, then a write to 0x17 with data 0x000A_05DC and req_ready=0 -> next cycle req_valid=1, len=1500, queue_idx=2, prio=2, sn=0, fifo_level=1.
- 3 writes, then req_ready held high -> sn 0,1,2 popped on 3 consecutive cycles; fifo_level ends at 0 and req_valid falls.
- Fill 64 entries, then one more write -> dropped, overflow=1, fifo_level=64. The next accepted push after a pop gets sn=64, not 65. With TX_REQ_DROP_CNT_EN, drop_cnt=1.
- Full FIFO with push and pop in the same cycle -> push dropped, level 63, overflow=1. Then write to 0x18 -> overflow=0 next cycle (drop_cnt=0 if enabled).
- 1030 push/pop pairs -> the 1025th request carries sn=0 (wrap); there are no gaps.
- Assert rst for 1 cycle with 5 entries queued -> req_valid=0 and fifo_level=0 next cycle. The next push gets sn=0.
